dcache_resp_model: RTL and testbench

//  Responder end of the core<->dcache request port (dcache_req_i_t / dcache_req_o_t).

---
 rtl/dcache_resp_model_if.sv | 28 ++
 rtl/dcache_resp_model.sv | 171 +++++++++++++++++
 tb/tb_dcache_resp_model.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_resp_model_if.sv
// Core <-> dcache request port, responder view.
// Request fields come from the load/store unit; grant/rvalid/rdata return from the cache side.
interface dcache_resp_model_if;
    logic [11:0] address_index;
    logic [43:0] address_tag;
    logic [63:0] data_wdata;
    logic        data_req;
    logic        data_we;
    logic [7:0]  data_be;
    logic [1:0]  data_size;
    logic        kill_req;
    logic        tag_valid;
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;

    modport master (
        output address_index, address_tag, data_wdata, data_req, data_we,
               data_be, data_size, kill_req, tag_valid,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  address_index, address_tag, data_wdata, data_req, data_we,
               data_be, data_size, kill_req, tag_valid,
        output data_gnt, data_rvalid, data_rdata
    );
endinterface

// File: rtl/dcache_resp_model.sv
// Cache-side stand-in for the core<->dcache request port.
// Single outstanding request against a small 64-bit word memory, with a
// configurable load latency and optional LFSR-driven grant stalls.
module dcache_resp_model #(
    parameter int         MEM_AW     = 10,
    parameter int         RD_LATENCY = 2,
    parameter int         GNT_STALL  = 0,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dcache_resp_model_if.slave dcache,
    output logic               wr_gnt_o,
    output logic               busy_o
);

    localparam int ADDR_W = 56;
    localparam int DEPTH  = 1 << MEM_AW;
    // The counter runs from RD_LATENCY-1 down to 0, so rvalid lands
    // exactly RD_LATENCY cycles after the tag-accept cycle plus one.
    localparam int CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TAG_WAIT = 2'd1,
        S_LAT_WAIT = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [7:0]        r_lfsr;
    logic              w_lfsr_fb;

    logic [11:0]       r_index;
    logic [MEM_AW-1:0] r_rd_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rvalid;
    logic [63:0]       r_rdata;
    logic [63:0]       r_mem [DEPTH];

    logic              w_gnt;
    logic              w_wr_en;
    logic              w_tag_accept;
    logic              w_enter_resp;
    logic [ADDR_W-1:0] w_req_full;
    logic [ADDR_W-1:0] w_tag_full;
    logic [MEM_AW-1:0] w_req_waddr;
    logic [MEM_AW-1:0] w_tag_waddr;
    logic [MEM_AW-1:0] w_rd_addr;
    logic              w_unused_bits;

    // Byte address -> word address; upper bits are dropped so addresses wrap.
    assign w_req_full  = {dcache.address_tag, dcache.address_index};
    assign w_tag_full  = {dcache.address_tag, r_index};
    assign w_req_waddr = w_req_full[MEM_AW+2:3];
    assign w_tag_waddr = w_tag_full[MEM_AW+2:3];

    // Byte offset, out-of-range address bits and data_size play no role.
    assign w_unused_bits = ^{w_req_full[2:0], w_req_full[ADDR_W-1:MEM_AW+3],
                             w_tag_full[2:0], w_tag_full[ADDR_W-1:MEM_AW+3],
                             dcache.data_size};

    assign w_wr_en      = w_gnt && dcache.data_we;
    assign w_tag_accept = (r_state == S_TAG_WAIT) && !dcache.kill_req && dcache.tag_valid;
    // RESP always returns to IDLE, so any transition into RESP is an entry.
    assign w_enter_resp = (w_next == S_RESP);
    // With zero latency the read happens straight from the tag phase.
    assign w_rd_addr    = (r_state == S_TAG_WAIT) ? w_tag_waddr : r_rd_addr;

    // Stall LFSR x^8+x^6+x^5+x^4+1, free-running outside reset.
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; kill wins over a same-cycle tag_valid.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gnt && !dcache.data_we) begin
                    w_next = S_TAG_WAIT;
                end
            end
            S_TAG_WAIT: begin
                if (dcache.kill_req) begin
                    w_next = S_IDLE;
                end else if (dcache.tag_valid) begin
                    w_next = (RD_LATENCY == 0) ? S_RESP : S_LAT_WAIT;
                end
            end
            S_LAT_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // FSM outputs: grant only in IDLE, optionally gated by the LFSR.
    always_comb begin
        w_gnt    = dcache.data_req && (r_state == S_IDLE) &&
                   ((GNT_STALL == 0) || r_lfsr[0]);
        wr_gnt_o = w_gnt && dcache.data_we;
        busy_o   = (r_state != S_IDLE);
    end

    assign dcache.data_gnt    = w_gnt;
    assign dcache.data_rvalid = r_rvalid;
    assign dcache.data_rdata  = r_rdata;

    // Load address capture and latency countdown.
    always_ff @(posedge clk_i) begin
        if (w_gnt && !dcache.data_we) begin
            r_index <= dcache.address_index;
        end
        if (w_tag_accept) begin
            r_rd_addr <= w_tag_waddr;
            r_cnt     <= CNT_W'((RD_LATENCY > 0) ? (RD_LATENCY - 1) : 0);
        end else if ((r_state == S_LAT_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Registered response: one-cycle rvalid, rdata holds between loads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_enter_resp;
            if (w_enter_resp) begin
                r_rdata <= r_mem[w_rd_addr];
            end
        end
    end

    // Byte-masked store into the word memory; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (dcache.data_be[b]) begin
                    r_mem[w_req_waddr][8*b +: 8] <= dcache.data_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_resp_model.sv
// Bench for dcache_resp_model: two instances share one stimulus driver,
// u_dut0 without grant stalls (latency 2) and u_dut1 with stalls (latency 1,
// 16-word memory), checked against a word-array model of the memory.
module tb_dcache_resp_model;

    localparam int         AW0   = 10;
    localparam int         RL0   = 2;
    localparam int         AW1   = 4;
    localparam int         RL1   = 1;
    localparam logic [7:0] SEED1 = 8'h5B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, sel;
    logic [11:0] d_index;
    logic [43:0] d_tag;
    logic [63:0] d_wdata;
    logic        d_req, d_we, d_kill, d_tagv;
    logic [7:0]  d_be;
    logic [1:0]  d_size;

    dcache_resp_model_if if0 ();
    dcache_resp_model_if if1 ();

    assign if0.address_index = d_index;
    assign if0.address_tag   = d_tag;
    assign if0.data_wdata    = d_wdata;
    assign if0.data_req      = d_req & ~sel;
    assign if0.data_we       = d_we;
    assign if0.data_be       = d_be;
    assign if0.data_size     = d_size;
    assign if0.kill_req      = d_kill;
    assign if0.tag_valid     = d_tagv;

    assign if1.address_index = d_index;
    assign if1.address_tag   = d_tag;
    assign if1.data_wdata    = d_wdata;
    assign if1.data_req      = d_req & sel;
    assign if1.data_we       = d_we;
    assign if1.data_be       = d_be;
    assign if1.data_size     = d_size;
    assign if1.kill_req      = d_kill;
    assign if1.tag_valid     = d_tagv;

    logic wrg0, wrg1, busy0, busy1;

    dcache_resp_model #(.MEM_AW(AW0), .RD_LATENCY(RL0), .GNT_STALL(0), .LFSR_SEED(8'hA5)) u_dut0 (
        .clk_i(clk), .rst_i(rst0), .dcache(if0.slave), .wr_gnt_o(wrg0), .busy_o(busy0)
    );

    dcache_resp_model #(.MEM_AW(AW1), .RD_LATENCY(RL1), .GNT_STALL(1), .LFSR_SEED(SEED1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .dcache(if1.slave), .wr_gnt_o(wrg1), .busy_o(busy1)
    );

    logic        w_gnt, w_rvalid, w_busy, w_wrgnt;
    logic [63:0] w_rdata;
    assign w_gnt    = sel ? if1.data_gnt    : if0.data_gnt;
    assign w_rvalid = sel ? if1.data_rvalid : if0.data_rvalid;
    assign w_rdata  = sel ? if1.data_rdata  : if0.data_rdata;
    assign w_busy   = sel ? busy1 : busy0;
    assign w_wrgnt  = sel ? wrg1  : wrg0;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [7:0]  lm;
    logic [63:0] mem0 [1024];
    logic [63:0] mem1 [16];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] rand64();
        logic [63:0] v = {$urandom(), $urandom()};
        return v;
    endfunction

    function automatic logic [43:0] rand_tag();
        logic [63:0] v = rand64();
        return v[43:0];
    endfunction

    function automatic logic [55:0] rand_addr();
        logic [63:0] v = rand64();
        return v[55:0];
    endfunction

    function automatic logic [63:0] mread(input logic [55:0] a);
        if (sel) return mem1[a[AW1+2:3]];
        return mem0[a[AW0+2:3]];
    endfunction

    task automatic mwrite(input logic [55:0] a, input logic [63:0] d, input logic [7:0] be);
        logic [63:0] w = mread(a);
        for (int b = 0; b < 8; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        if (sel) mem1[a[AW1+2:3]] = w;
        else     mem0[a[AW0+2:3]] = w;
    endtask

    // Reference stall LFSR for the stalling instance.
    always @(posedge clk) lm <= rst1 ? SEED1 : {lm[6:0], ^(lm & 8'hB8)};

    // Per-cycle grant legality on both instances.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst0) begin
                check_eq("gnt0_rule", if0.data_gnt, if0.data_req & ~busy0);
                check_eq("wrgnt0_rule", wrg0, if0.data_gnt & if0.data_we);
                if (if0.data_rvalid) check_eq("rvalid0_busy", busy0, 1'b1);
            end
            if (!rst1) begin
                check_eq("gnt1_rule", if1.data_gnt, if1.data_req & ~busy1 & lm[0]);
                check_eq("wrgnt1_rule", wrg1, if1.data_gnt & if1.data_we);
            end
        end
    end

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (w_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("gnt_timeout", w_gnt, 1'b1);
    endtask

    task automatic do_store(input logic [55:0] a, input logic [63:0] d, input logic [7:0] be);
        bit ok;
        @(posedge clk); #1;
        d_index = a[11:0]; d_tag = a[55:12]; d_wdata = d; d_be = be; d_we = 1'b1; d_req = 1'b1;
        wait_gnt(ok);
        if (ok) begin
            check_eq("wr_gnt", w_wrgnt, 1'b1);
            mwrite(a, d, be);
        end
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0; d_wdata = rand64();
        @(negedge clk);
        check_eq("wr_gnt_once", w_wrgnt, 1'b0);
    endtask

    // Load with td cycles of tag delay; optional kill in the tag phase, or a
    // request held through the busy period.
    task automatic do_load(input logic [55:0] a, input int td, input bit kill, input bit hold);
        bit          ok;
        int          rl   = sel ? RL1 : RL0;
        logic [63:0] exp  = mread(a);
        logic [63:0] prev = w_rdata;
        @(posedge clk); #1;
        d_index = a[11:0]; d_tag = rand_tag(); d_we = 1'b0; d_req = 1'b1;
        wait_gnt(ok);
        if (!ok) begin
            d_req = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!hold) d_req = 1'b0;
        d_index = rand_tag()[11:0];
        if (kill) begin
            d_kill = 1'b1; d_tagv = 1'($urandom_range(0, 1)); d_tag = a[55:12];
            @(negedge clk);
            check_eq("kill_cycle_busy", w_busy, 1'b1);
            @(posedge clk); #1;
            d_kill = 1'b0; d_tagv = 1'b0; d_we = 1'b1; d_be = 8'h00; d_req = 1'b1;
            @(negedge clk);
            check_eq("busy_after_kill", w_busy, 1'b0);
            check_eq("gnt_after_kill", w_gnt, sel ? lm[0] : 1'b1);
            @(posedge clk); #1;
            d_req = 1'b0; d_we = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check_eq("kill_no_rvalid", w_rvalid, 1'b0);
                check_eq("kill_rdata_hold", w_rdata, prev);
            end
            return;
        end
        for (int i = 0; i < td; i++) begin
            @(negedge clk);
            check_eq("rvalid_before_tag", w_rvalid, 1'b0);
            check_eq("busy_tag_wait", w_busy, 1'b1);
            if (hold) check_eq("gnt_while_busy", w_gnt, 1'b0);
            @(posedge clk); #1;
            d_tag = rand_tag();
        end
        d_tag = a[55:12]; d_tagv = 1'b1;
        for (int k = 0; k <= rl + 1; k++) begin
            @(negedge clk);
            check_eq("rvalid_timing", w_rvalid, k == rl + 1);
            if (k == rl + 1) check_eq("rdata", w_rdata, exp);
            if (hold) check_eq("gnt_while_busy", w_gnt, 1'b0);
            @(posedge clk); #1;
            d_tagv = 1'b0; d_tag = rand_tag();
        end
        @(negedge clk);
        check_eq("rvalid_one_cycle", w_rvalid, 1'b0);
        check_eq("rdata_hold", w_rdata, exp);
        if (hold) begin
            check_eq("gnt_after_rvalid", w_gnt, 1'b1);
            @(posedge clk); #1;
            d_req = 1'b0; d_kill = 1'b1;
            @(posedge clk); #1;
            d_kill = 1'b0;
            @(negedge clk);
            check_eq("busy_after_hold_kill", w_busy, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        logic [55:0] a;
        logic [63:0] x7;
        rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0;
        d_index = '0; d_tag = '0; d_wdata = '0; d_req = 1'b0; d_we = 1'b0;
        d_be = '0; d_size = 2'd3; d_kill = 1'b0; d_tagv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check_eq("rst_busy0", busy0, 1'b0);
        check_eq("rst_rvalid0", if0.data_rvalid, 1'b0);
        check_eq("rst_rdata0", if0.data_rdata, 64'h0);
        check_eq("rst_gnt0", if0.data_gnt, 1'b0);
        check_eq("rst_busy1", busy1, 1'b0);
        check_eq("rst_rvalid1", if1.data_rvalid, 1'b0);
        check_eq("rst_rdata1", if1.data_rdata, 64'h0);
        mon_en = 1'b1;

        // Full store then load with no tag delay.
        do_store(56'd40, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        do_load(56'd40, 0, 1'b0, 1'b0);
        check_eq("t1_value", w_rdata, 64'hDEADBEEF_CAFEF00D);

        // Partial-byte store merges into the existing word.
        do_store(56'd40, 64'h00000000_11223344, 8'h0F);
        do_load(56'd40, 0, 1'b0, 1'b0);
        check_eq("t2_merge", w_rdata, 64'hDEADBEEF_11223344);

        // Kill in the tag phase, then tag delay with a request held while busy.
        do_load(56'd40, 0, 1'b1, 1'b0);
        do_load(56'd40, 3, 1'b0, 1'b1);

        // Reset during the latency wait drops the load; memory survives.
        @(posedge clk); #1;
        d_index = 12'd40; d_tag = '0; d_we = 1'b0; d_req = 1'b1;
        wait_gnt(ok);
        @(posedge clk); #1;
        d_req = 1'b0; d_tagv = 1'b1;
        @(posedge clk); #1;
        d_tagv = 1'b0;
        @(negedge clk);
        check_eq("t6_busy_lat", w_busy, 1'b1);
        check_eq("t6_no_rvalid_lat", w_rvalid, 1'b0);
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        x7 = rand64();
        d_index = 12'd56; d_tag = '0; d_wdata = x7; d_be = 8'hFF; d_we = 1'b1; d_req = 1'b1;
        @(negedge clk);
        check_eq("t6_gnt_after_rst", w_gnt, 1'b1);
        check_eq("t6_rvalid_rst", w_rvalid, 1'b0);
        check_eq("t6_rdata_rst", w_rdata, 64'h0);
        check_eq("t6_busy_rst", w_busy, 1'b0);
        mwrite(56'd56, x7, 8'hFF);
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t6_no_rvalid", w_rvalid, 1'b0);
        end
        do_load(56'd40, 0, 1'b0, 1'b0);
        check_eq("t6_mem_kept", w_rdata, 64'hDEADBEEF_11223344);
        do_load(56'd56, 1, 1'b0, 1'b0);

        // Address bits above the memory wrap onto the low words.
        do_store(56'd0, 64'h0123_4567_89AB_CDEF, 8'hFF);
        do_load(56'd1 << (AW0 + 3), 0, 1'b0, 1'b0);
        check_eq("t7_alias", w_rdata, 64'h0123_4567_89AB_CDEF);
        do_store((56'd1 << (AW0 + 3)) | 56'd24, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
        do_load(56'd24, 0, 1'b0, 1'b0);
        check_eq("t7_alias_store", w_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
        do_load((56'd1 << 40) | 56'd24, 2, 1'b0, 1'b0);

        // Random traffic on the stalling instance.
        @(posedge clk); #1;
        sel = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = rand_addr();
            a[6:3] = 4'(i);
            do_store(a, rand64(), 8'hFF);
        end
        for (int n = 0; n < 200; n++) begin
            int r = $urandom_range(0, 9);
            a = rand_addr();
            if (r < 4)      do_store(a, rand64(), 8'($urandom()));
            else if (r < 8) do_load(a, $urandom_range(0, 2), 1'b0, 1'b0);
            else            do_load(a, 0, 1'b1, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
